// File: rtl/sa_result_uart_framer_if.sv
// Result-word handshake from the systolic array plus the byte handshake to the 8N1 UART,
// bundled for the framer (slave side) and its environment (master side).
interface sa_result_uart_framer_if #(
  parameter int DATA_W = 32
);
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic [7:0]        tx_byte;
  logic              tx_send;
  logic              tx_done;

  modport master (
    output res_valid, res_data, tx_done,
    input  res_ready, tx_byte, tx_send
  );

  modport slave (
    input  res_valid, res_data, tx_done,
    output res_ready, tx_byte, tx_send
  );
endinterface

// File: rtl/sa_result_uart_framer.sv
// Buffers systolic-array result words and sends each as SYNC, data bytes LSB-first, CHECK.
// Define SA_FRAMER_CRC8_EN for a CRC-8 (poly 0x07) check byte; otherwise the check is an XOR.
module sa_result_uart_framer #(
  parameter int         DATA_W     = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  sa_result_uart_framer_if.slave bus,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic [15:0]            frames_sent_o
);
  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(NB + 2);
  localparam logic [IDX_W-1:0] IDX_NB  = IDX_W'(NB);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, WAIT = 2'd3} state_e;

  function automatic logic [7:0] check_fold(input logic [7:0] acc, input logic [7:0] data);
`ifdef SA_FRAMER_CRC8_EN
    logic [7:0] c;
    c = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    return c;
`else
    return acc ^ data;
`endif
  endfunction

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [7:0]        check_q, check_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_send_q, tx_send_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       frames_q, frames_d;
  logic              empty_s, full_s, push_s, pop_s;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_s  = bus.res_valid && !full_s;
  assign pop_s   = (state_q == IDLE) && !empty_s;

  assign bus.res_ready = !full_s;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_send   = tx_send_q;
  assign busy_o        = busy_q;
  assign overflow_o    = overflow_q;
  assign frames_sent_o = frames_q;

  // Next-state and datapath for the frame sequencer and FIFO pointers.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    check_d    = check_q;
    idx_d      = idx_q;
    tx_byte_d  = tx_byte_q;
    tx_send_d  = 1'b0;
    frames_d   = frames_q;
    overflow_d = overflow_q | (bus.res_valid & full_s);
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = LOAD;
          shift_d = fifo_q[rd_ptr_q[PTR_W-1:0]];
          check_d = 8'h00;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        tx_byte_d = SYNC_BYTE;
        tx_send_d = 1'b1;
        state_d   = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (!bus.tx_done) begin
          state_d = WAIT;
        end else if (idx_q < IDX_NB) begin
          tx_byte_d = shift_q[7:0];
          check_d   = check_fold(check_q, shift_q[7:0]);
          shift_d   = {8'h00, shift_q[DATA_W-1:8]};
          idx_d     = idx_q + IDX_ONE;
          tx_send_d = 1'b1;
          state_d   = SEND;
        end else if (idx_q == IDX_NB) begin
          tx_byte_d = check_q;
          idx_d     = idx_q + IDX_ONE;
          tx_send_d = 1'b1;
          state_d   = SEND;
        end else begin
          frames_d = frames_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    busy_d   = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      check_q    <= 8'h00;
      idx_q      <= '0;
      tx_byte_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      frames_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      check_q    <= check_d;
      idx_q      <= idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_send_q  <= tx_send_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      frames_q   <= frames_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_s) fifo_q[wr_ptr_q[PTR_W-1:0]] <= bus.res_data;
  end
endmodule

// File: tb/tb_sa_result_uart_framer.sv
// Directed bench for sa_result_uart_framer with a stub UART answering tx_done 20 cycles
// after each tx_send; expected frames are hand-computed constants.
module tb_sa_result_uart_framer;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy, overflow;
  logic [15:0] frames_sent;

  sa_result_uart_framer_if #(.DATA_W(DATA_W)) bus ();

  sa_result_uart_framer #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy_o(busy), .overflow_o(overflow), .frames_sent_o(frames_sent)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          send_wide = 0;
  int          exp_frames = 0;
  logic [7:0]  cap[$];
  logic [7:0]  exp_q[$];
  logic        uart_en = 1'b1;
  logic        stub_done = 1'b0;
  logic        inj_done = 1'b0;
  logic        pend = 1'b0;
  logic        prev_send = 1'b0;
  int          cnt = 0;

  assign bus.tx_done = stub_done | inj_done;

  // Stub UART: records every byte, flags over-wide tx_send, answers tx_done after 20 cycles.
  always @(negedge clk) begin
    stub_done = 1'b0;
    if (reset) begin
      pend = 1'b0;
      cnt = 0;
      prev_send = 1'b0;
    end else begin
      if (pend && uart_en) begin
        if (cnt <= 1) begin
          stub_done = 1'b1;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (bus.tx_send) begin
        cap.push_back(bus.tx_byte);
        if (prev_send) send_wide++;
        pend = 1'b1;
        cnt = 20;
      end
      prev_send = bus.tx_send;
    end
  end

  function automatic logic [7:0] exp_check(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 0; b < 4; b++) begin
      c = c ^ w[8*b +: 8];
`ifdef SA_FRAMER_CRC8_EN
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
`endif
    end
    return c;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic add_frame(input logic [31:0] w, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    exp_q.push_back(chk);
    exp_frames++;
  endtask

  task automatic push(input logic [31:0] w);
    bus.res_valid = 1'b1;
    bus.res_data  = w;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (cap.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.tx_send !== 1'b0) begin n_bad++; $display("FAIL reset_tx_send: got %b want 0", bus.tx_send); end
    n_cmp++; if (bus.tx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
    n_cmp++; if (bus.res_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.res_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    bit ok;
    cap.delete(); exp_q.delete();
    add_frame(32'h12345678, `ifdef SA_FRAMER_CRC8_EN exp_check(32'h12345678) `else 8'h08 `endif);
    push(32'h12345678);
    n_cmp++; if (bus.tx_send !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL lat_k: send=%b busy=%b want 0 1", bus.tx_send, busy); end
    tick();
    n_cmp++; if (bus.tx_send !== 1'b0) begin n_bad++; $display("FAIL lat_k1: got %b want 0", bus.tx_send); end
    tick();
    n_cmp++; if (bus.tx_send !== 1'b1 || bus.tx_byte !== 8'hA5) begin n_bad++; $display("FAIL lat_k2: send=%b byte=%h want 1 a5", bus.tx_send, bus.tx_byte); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t1_timeout: got %b want 1", ok); end
    n_cmp++; if (cap.size() != exp_q.size()) begin n_bad++; $display("FAIL t1_len: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL t1_byte%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (send_wide != 0) begin n_bad++; $display("FAIL t1_pulse: got %0d wide pulses want 0", send_wide); end
    n_cmp++; if (frames_sent !== 16'(exp_frames)) begin n_bad++; $display("FAIL t1_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_check_byte();
    bit ok;
    cap.delete(); exp_q.delete();
    add_frame(32'h00000001, `ifdef SA_FRAMER_CRC8_EN 8'h16 `else 8'h01 `endif);
    push(32'h00000001);
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t2_timeout: got %b want 1", ok); end
    n_cmp++; if (cap.size() != exp_q.size()) begin n_bad++; $display("FAIL t2_len: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL t2_byte%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    cap.delete(); exp_q.delete();
    add_frame(32'hFFFFFFFF, `ifdef SA_FRAMER_CRC8_EN exp_check(32'hFFFFFFFF) `else 8'h00 `endif);
    add_frame(32'h80000000, `ifdef SA_FRAMER_CRC8_EN exp_check(32'h80000000) `else 8'h80 `endif);
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hFFFFFFFF;
    tick();
    bus.res_data  = 32'h80000000;
    tick();
    bus.res_valid = 1'b0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t6_timeout: got %b want 1", ok); end
    n_cmp++; if (cap.size() != exp_q.size()) begin n_bad++; $display("FAIL t6_len: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL t6_byte%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (frames_sent !== 16'(exp_frames)) begin n_bad++; $display("FAIL t6_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] words [5];
    logic        exp_rdy [5];
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cap.delete(); exp_q.delete();
    uart_en = 1'b0;
    add_frame(32'hCAFE0001, exp_check(32'hCAFE0001));
    push(32'hCAFE0001);
    wait_bytes(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t3_prime: got %b want 1", ok); end
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = words[i];
      n_cmp++; if (bus.res_ready !== exp_rdy[i]) begin n_bad++; $display("FAIL t3_ready%0d: got %b want %b", i, bus.res_ready, exp_rdy[i]); end
      if (i < 4) add_frame(words[i], exp_check(words[i]));
      tick();
    end
    bus.res_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL t3_overflow: got %b want 1", overflow); end
    uart_en = 1'b1;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t3_timeout: got %b want 1", ok); end
    n_cmp++; if (cap.size() != exp_q.size()) begin n_bad++; $display("FAIL t3_len: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL t3_byte%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL t3_sticky: got %b want 1", overflow); end
    n_cmp++; if (frames_sent !== 16'(exp_frames)) begin n_bad++; $display("FAIL t3_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_ignore_done();
    bit ok;
    cap.delete(); exp_q.delete();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0 || cap.size() != 0) begin n_bad++; $display("FAIL t5_idle: busy=%b sends=%0d want 0 0", busy, cap.size()); end
    add_frame(32'h0BADF00D, exp_check(32'h0BADF00D));
    push(32'h0BADF00D);
    wait_bytes(1, ok);
    n_cmp++; if (ok !== 1'b1 || bus.tx_send !== 1'b1) begin n_bad++; $display("FAIL t5_send: ok=%b send=%b want 1 1", ok, bus.tx_send); end
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t5_timeout: got %b want 1", ok); end
    n_cmp++; if (cap.size() != exp_q.size()) begin n_bad++; $display("FAIL t5_len: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL t5_byte%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (frames_sent !== 16'(exp_frames)) begin n_bad++; $display("FAIL t5_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    cap.delete(); exp_q.delete();
    push(32'hDEADBEEF);
    wait_bytes(3, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t4_reach: got %b want 1", ok); end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.tx_send !== 1'b0) begin n_bad++; $display("FAIL t4_send: got %b want 0", bus.tx_send); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t4_busy: got %b want 0", busy); end
    n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL t4_frames: got %0d want 0", frames_sent); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL t4_overflow: got %b want 0", overflow); end
    tick();
    reset = 1'b0;
    cap.delete();
    exp_frames = 0;
    repeat (30) tick();
    n_cmp++; if (cap.size() != 0) begin n_bad++; $display("FAIL t4_quiet: got %0d sends want 0", cap.size()); end
    add_frame(32'h0000ABCD, exp_check(32'h0000ABCD));
    push(32'h0000ABCD);
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t4_timeout: got %b want 1", ok); end
    n_cmp++; if (cap.size() != exp_q.size()) begin n_bad++; $display("FAIL t4_len: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_bad++; $display("FAIL t4_byte%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (frames_sent !== 16'd1) begin n_bad++; $display("FAIL t4_frames_after: got %0d want 1", frames_sent); end
  endtask

  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    test_reset();
    test_single_frame();
    test_check_byte();
    test_back_to_back();
    test_overflow();
    test_ignore_done();
    test_reset_midframe();
    n_cmp++; if (send_wide != 0) begin n_bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", send_wide); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
